dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Two-requester controller that shares the single 64-bit, byte-addressed, little-endian data memory between requesters. Requester 0 is the core load/store unit and requester 1 is the testbench/DMA loader. Arbitrates round-robin, sequences memory accesses, performs read-modify-write for sub-doubleword stores, and extracts and extends sub-doubleword loads. Sits between the requesters and the memory's combinational read / level-sensitive write port.

Parameters:
DATA_WIDTH, 64, data and address width; the block supports only 64.
NUM_REQ, 2, number of requesters; fixed at 2, used only for vector sizing.

Ports:
in_clk  input  1  clock, rising edge
in_rst_n  input  1  asynchronous active-low reset
in_req_valid  input  2  per-requester request valid
out_req_ready  output  2  per-requester accept; at most one bit high
in_req_wr  input  2  1 = store, 0 = load
in_req_size  input  4  2 bits per requester: 0 = byte, 1 = half, 2 = word, 3 = double
in_req_unsigned  input  2  load zero-extend (1) or sign-extend (0)
in_req_addr  input  128  64-bit byte address per requester; [63:0] is requester 0
in_req_wdata  input  128  64-bit store data per requester; low bytes used
out_rsp_valid  output  1  one-cycle response pulse
out_rsp_id  output  1  requester index for the response
out_rsp_data  output  64  load result; 0 for stores
out_mem_addr  output  64  memory address, registered
out_mem_wdata  output  64  memory write data, registered
out_mem_wr_en  output  1  memory write enable, registered
in_mem_rdata  input  64  memory read data, combinational from out_mem_addr
out_busy  output  1  state != IDLE

Behaviour:
- States: IDLE, RD, WR, RSP. Encoded registers; all outputs are registered or decoded from the state register.
- Reset (async, in_rst_n = 0): state = IDLE, last_grant = 1, every output = 0. Reset mid-operation aborts the operation and emits no response. out_mem_wr_en drops immediately, so a partial write never lingers.
- Arbitration, IDLE only:
  - grant = the single valid requester.
  - If both are valid, grant = !last_grant.
  - out_req_ready[grant] = 1 combinationally; all other ready bits = 0.
  - Accept = valid & ready at a rising edge. At accept: capture wr, size, unsigned, addr, wdata and id; last_grant <= grant.
  - A requester must hold its request until accepted. Fields may change after the accept edge.
- Load: IDLE -accept-> RD -> RSP -> IDLE.
  - RD: out_mem_addr = addr. At the end of RD, register the lowest (1<<size) bytes of in_mem_rdata, sign- or zero-extended to 64.
  - RSP: out_rsp_valid = 1, out_rsp_id and out_rsp_data valid.
  - Response appears 2 cycles after the accept edge.
- Doubleword store: IDLE -> WR -> RSP -> IDLE.
  - WR: out_mem_wr_en = 1 for exactly one cycle, with addr and wdata stable for the whole cycle.
  - RSP carries data 0.
- Sub-doubleword store: IDLE -> RD -> WR -> RSP -> IDLE.
  - WR data = low (1<<size) bytes of wdata merged over the upper bytes of the old 64-bit value read in RD.
  - Bytes addr+(1<<size) .. addr+7 are rewritten unchanged.
- out_mem_wr_en is 0 in every state except WR. out_mem_wdata = 0 outside WR. out_mem_addr holds its last value in IDLE.
- No new accept in RD, WR or RSP. The earliest next accept is the cycle after RSP. A request arriving during RSP is granted next cycle.
- Addresses wrap modulo 2^64. Without the optional feature, alignment is not checked: the memory handles unaligned 8-byte windows.
- Back-to-back requests from both requesters alternate: 0, 1, 0, 1, ...

Optional Feature:
DMEM_ARB_MISALIGN_TRAP_EN.
- Defined: adds port out_rsp_err (output, 1 bit, reset 0).
  - An accepted request with addr mod (1<<size) != 0 makes no memory access: IDLE -> RSP.
  - That response has out_rsp_err = 1 and out_rsp_data = 0.
  - Aligned requests behave as above with out_rsp_err = 0.
- Undefined: port absent, no check, misaligned accesses are performed normally.

Test Plan:
- Doubleword store from r0, addr 0x100, data 0x1122334455667788, then a doubleword load from 0x100 -> one wr_en pulse; load response 2 cycles after accept with data 0x1122334455667788, id 0.
- Byte store from r1, addr 0x100, wdata 0xAB; then load size 3 -> RD then WR; memory reads 0x11223344556677AB; response id 1.
- Load byte from 0x100 holding 0xAB, unsigned = 0 -> 0xFFFFFFFFFFFFFFAB; unsigned = 1 -> 0x00000000000000AB. Load half from 0x106 (bytes 0x22, 0x11) -> 0x1122.
- Both requesters valid continuously for 4 requests after reset -> grants r0, r1, r0, r1. Ready is never high on both. Each response id matches its request.
- Reset asserted during the WR state of a half store -> out_mem_wr_en falls immediately, no response, outputs 0, and the first grant after reset goes to r0.
- With DMEM_ARB_MISALIGN_TRAP_EN: word load at 0x102 -> no RD, response next cycle with out_rsp_err = 1 and data 0. Without the macro: data = bytes 0x102..0x105, sign-extended.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Requester, response and memory-side bundle of the data-memory arbiter.
// The rsp_err signal exists only when DMEM_ARB_MISALIGN_TRAP_EN is defined.
interface dmem_arbiter_if #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_REQ    = 2
);
  logic [NUM_REQ-1:0]            in_req_valid;
  logic [NUM_REQ-1:0]            out_req_ready;
  logic [NUM_REQ-1:0]            in_req_wr;
  logic [2*NUM_REQ-1:0]          in_req_size;
  logic [NUM_REQ-1:0]            in_req_unsigned;
  logic [DATA_WIDTH*NUM_REQ-1:0] in_req_addr;
  logic [DATA_WIDTH*NUM_REQ-1:0] in_req_wdata;
  logic                          out_rsp_valid;
  logic                          out_rsp_id;
  logic [DATA_WIDTH-1:0]         out_rsp_data;
`ifdef DMEM_ARB_MISALIGN_TRAP_EN
  logic                          out_rsp_err;
`endif
  logic [DATA_WIDTH-1:0]         out_mem_addr;
  logic [DATA_WIDTH-1:0]         out_mem_wdata;
  logic                          out_mem_wr_en;
  logic [DATA_WIDTH-1:0]         in_mem_rdata;
  logic                          out_busy;

  modport slave (
    input  in_req_valid, in_req_wr, in_req_size, in_req_unsigned, in_req_addr, in_req_wdata,
    input  in_mem_rdata,
    output out_req_ready, out_rsp_valid, out_rsp_id, out_rsp_data,
`ifdef DMEM_ARB_MISALIGN_TRAP_EN
    output out_rsp_err,
`endif
    output out_mem_addr, out_mem_wdata, out_mem_wr_en, out_busy
  );

  modport master (
    output in_req_valid, in_req_wr, in_req_size, in_req_unsigned, in_req_addr, in_req_wdata,
    output in_mem_rdata,
    input  out_req_ready, out_rsp_valid, out_rsp_id, out_rsp_data,
`ifdef DMEM_ARB_MISALIGN_TRAP_EN
    input  out_rsp_err,
`endif
    input  out_mem_addr, out_mem_wdata, out_mem_wr_en, out_busy
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin two-requester controller for the shared 64-bit little-endian data memory.
// Optional misalignment trap: define DMEM_ARB_MISALIGN_TRAP_EN.
module dmem_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_REQ    = 2
) (
  input logic           in_clk,
  input logic           in_rst_n,
  dmem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_RSP  = 2'd3
  } state_t;

  function automatic logic [63:0] load_extend(input logic [63:0] raw, input logic [1:0] size,
                                              input logic uns);
    logic [63:0] res;
    case (size)
      2'd0:    res = uns ? {56'd0, raw[7:0]}  : {{56{raw[7]}}, raw[7:0]};
      2'd1:    res = uns ? {48'd0, raw[15:0]} : {{48{raw[15]}}, raw[15:0]};
      2'd2:    res = uns ? {32'd0, raw[31:0]} : {{32{raw[31]}}, raw[31:0]};
      default: res = raw;
    endcase
    return res;
  endfunction

  function automatic logic [63:0] store_merge(input logic [63:0] old, input logic [63:0] wdata,
                                              input logic [1:0] size);
    logic [63:0] mask;
    case (size)
      2'd0:    mask = 64'h0000_0000_0000_00FF;
      2'd1:    mask = 64'h0000_0000_0000_FFFF;
      2'd2:    mask = 64'h0000_0000_FFFF_FFFF;
      default: mask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    return (wdata & mask) | (old & ~mask);
  endfunction

`ifdef DMEM_ARB_MISALIGN_TRAP_EN
  function automatic logic misaligned(input logic [2:0] addr_lo, input logic [1:0] size);
    logic [2:0] mask;
    case (size)
      2'd0:    mask = 3'b000;
      2'd1:    mask = 3'b001;
      2'd2:    mask = 3'b011;
      default: mask = 3'b111;
    endcase
    return (addr_lo & mask) != 3'b000;
  endfunction
`endif

  state_t                state_r, state_nxt_s;
  logic                  last_grant_r, grant_s, accept_s, misalign_s;
  logic [NUM_REQ-1:0]    ready_s;
  logic                  sel_wr_s, sel_uns_s;
  logic [1:0]            sel_size_s;
  logic [DATA_WIDTH-1:0] sel_addr_s, sel_wdata_s;
  logic                  wr_r, uns_r, id_r;
  logic [1:0]            size_r;
  logic [DATA_WIDTH-1:0] wdata_r;
  logic [DATA_WIDTH-1:0] mem_addr_r, mem_addr_nxt_s, mem_wdata_r, mem_wdata_nxt_s;
  logic [DATA_WIDTH-1:0] rsp_data_r, rsp_data_nxt_s;
  logic                  mem_wr_en_r, mem_wr_en_nxt_s, rsp_valid_r, rsp_valid_nxt_s;
  logic                  rsp_id_r, rsp_id_nxt_s;
`ifdef DMEM_ARB_MISALIGN_TRAP_EN
  logic                  rsp_err_r, rsp_err_nxt_s;
`endif

  // Grant selection and request field mux; ready only while idle
  always_comb begin
    if (bus.in_req_valid == 2'b11) begin
      grant_s = ~last_grant_r;
    end else if (bus.in_req_valid[0]) begin
      grant_s = 1'b0;
    end else begin
      grant_s = 1'b1;
    end
    accept_s    = (state_r == ST_IDLE) && bus.in_req_valid[grant_s];
    ready_s     = {NUM_REQ{1'b0}};
    ready_s[grant_s] = accept_s;
    sel_wr_s    = bus.in_req_wr[grant_s];
    sel_uns_s   = bus.in_req_unsigned[grant_s];
    sel_size_s  = grant_s ? bus.in_req_size[3:2] : bus.in_req_size[1:0];
    sel_addr_s  = grant_s ? bus.in_req_addr[127:64] : bus.in_req_addr[63:0];
    sel_wdata_s = grant_s ? bus.in_req_wdata[127:64] : bus.in_req_wdata[63:0];
`ifdef DMEM_ARB_MISALIGN_TRAP_EN
    misalign_s  = misaligned(sel_addr_s[2:0], sel_size_s);
`else
    misalign_s  = 1'b0;
`endif
  end

  // State register
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && misalign_s) begin
          state_nxt_s = ST_RSP;
        end else if (accept_s) begin
          state_nxt_s = (sel_wr_s && (sel_size_s == 2'd3)) ? ST_WR : ST_RD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RD:   state_nxt_s = wr_r ? ST_WR : ST_RSP;
      ST_WR:   state_nxt_s = ST_RSP;
      ST_RSP:  state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Next values of the registered memory and response outputs
  always_comb begin
    mem_addr_nxt_s  = mem_addr_r;
    mem_wdata_nxt_s = {DATA_WIDTH{1'b0}};
    mem_wr_en_nxt_s = 1'b0;
    rsp_valid_nxt_s = 1'b0;
    rsp_id_nxt_s    = 1'b0;
    rsp_data_nxt_s  = {DATA_WIDTH{1'b0}};
`ifdef DMEM_ARB_MISALIGN_TRAP_EN
    rsp_err_nxt_s   = 1'b0;
`endif
    case (state_r)
      ST_IDLE: begin
        if (accept_s && misalign_s) begin
          rsp_valid_nxt_s = 1'b1;
          rsp_id_nxt_s    = grant_s;
`ifdef DMEM_ARB_MISALIGN_TRAP_EN
          rsp_err_nxt_s   = 1'b1;
`endif
        end else if (accept_s) begin
          mem_addr_nxt_s  = sel_addr_s;
          mem_wr_en_nxt_s = (state_nxt_s == ST_WR);
          mem_wdata_nxt_s = (state_nxt_s == ST_WR) ? sel_wdata_s : {DATA_WIDTH{1'b0}};
        end else begin
          mem_addr_nxt_s  = mem_addr_r;
        end
      end
      ST_RD: begin
        // Stores read the old doubleword here so untouched upper bytes are rewritten as-is
        if (wr_r) begin
          mem_wr_en_nxt_s = 1'b1;
          mem_wdata_nxt_s = store_merge(bus.in_mem_rdata, wdata_r, size_r);
        end else begin
          rsp_valid_nxt_s = 1'b1;
          rsp_id_nxt_s    = id_r;
          rsp_data_nxt_s  = load_extend(bus.in_mem_rdata, size_r, uns_r);
        end
      end
      ST_WR: begin
        rsp_valid_nxt_s = 1'b1;
        rsp_id_nxt_s    = id_r;
      end
      ST_RSP:  rsp_valid_nxt_s = 1'b0;
      default: rsp_valid_nxt_s = 1'b0;
    endcase
  end

  // Output registers and captured request fields
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      last_grant_r <= 1'b1;
      wr_r         <= 1'b0;
      uns_r        <= 1'b0;
      id_r         <= 1'b0;
      size_r       <= 2'd0;
      wdata_r      <= {DATA_WIDTH{1'b0}};
      mem_addr_r   <= {DATA_WIDTH{1'b0}};
      mem_wdata_r  <= {DATA_WIDTH{1'b0}};
      mem_wr_en_r  <= 1'b0;
      rsp_valid_r  <= 1'b0;
      rsp_id_r     <= 1'b0;
      rsp_data_r   <= {DATA_WIDTH{1'b0}};
`ifdef DMEM_ARB_MISALIGN_TRAP_EN
      rsp_err_r    <= 1'b0;
`endif
    end else begin
      if (accept_s) begin
        last_grant_r <= grant_s;
        wr_r         <= sel_wr_s;
        uns_r        <= sel_uns_s;
        id_r         <= grant_s;
        size_r       <= sel_size_s;
        wdata_r      <= sel_wdata_s;
      end
      mem_addr_r   <= mem_addr_nxt_s;
      mem_wdata_r  <= mem_wdata_nxt_s;
      mem_wr_en_r  <= mem_wr_en_nxt_s;
      rsp_valid_r  <= rsp_valid_nxt_s;
      rsp_id_r     <= rsp_id_nxt_s;
      rsp_data_r   <= rsp_data_nxt_s;
`ifdef DMEM_ARB_MISALIGN_TRAP_EN
      rsp_err_r    <= rsp_err_nxt_s;
`endif
    end
  end

  assign bus.out_req_ready = ready_s;
  assign bus.out_busy      = (state_r != ST_IDLE);
  assign bus.out_mem_addr  = mem_addr_r;
  assign bus.out_mem_wdata = mem_wdata_r;
  assign bus.out_mem_wr_en = mem_wr_en_r;
  assign bus.out_rsp_valid = rsp_valid_r;
  assign bus.out_rsp_id    = rsp_id_r;
  assign bus.out_rsp_data  = rsp_data_r;
`ifdef DMEM_ARB_MISALIGN_TRAP_EN
  assign bus.out_rsp_err   = rsp_err_r;
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: byte-array memory model, hand-computed expectations.
// Misaligned-load expectations switch on DMEM_ARB_MISALIGN_TRAP_EN.
module tb_dmem_arbiter;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   cyc_cnt;
  int   wr_cnt;
  int   rsp_cnt;
  logic last_err;
  logic [7:0] mem [0:4095];

  dmem_arbiter_if bus ();

  dmem_arbiter dut (
    .in_clk   (clk),
    .in_rst_n (rst_n),
    .bus      (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory: combinational read of an 8-byte window, write on the clock while enabled
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      bus.in_mem_rdata[8*i +: 8] = mem[bus.out_mem_addr[11:0] + 12'(i)];
    end
  end

  always @(posedge clk) begin
    cyc_cnt <= cyc_cnt + 1;
    if (bus.out_mem_wr_en) begin
      for (int i = 0; i < 8; i++) begin
        mem[bus.out_mem_addr[11:0] + 12'(i)] <= bus.out_mem_wdata[8*i +: 8];
      end
    end
  end

  always @(negedge clk) begin
    if (bus.out_mem_wr_en) wr_cnt <= wr_cnt + 1;
    if (bus.out_rsp_valid) rsp_cnt <= rsp_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int r, input logic wr, input logic [1:0] size, input logic uns,
                       input logic [63:0] addr, input logic [63:0] wdata);
    bus.in_req_wr[r]             = wr;
    bus.in_req_size[2*r +: 2]    = size;
    bus.in_req_unsigned[r]       = uns;
    bus.in_req_addr[64*r +: 64]  = addr;
    bus.in_req_wdata[64*r +: 64] = wdata;
    bus.in_req_valid[r]          = 1'b1;
  endtask

  // Issue one request, wait for its accept and response; lat counts the accept cycle as 0
  task automatic xact(input string tag, input int r, input logic wr, input logic [1:0] size,
                      input logic uns, input logic [63:0] addr, input logic [63:0] wdata,
                      input int exp_lat, input logic [63:0] exp_data, input int exp_wr);
    bit ok;
    int cyc;
    int wr0;
    @(negedge clk);
    drive(r, wr, size, uns, addr, wdata);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (bus.out_req_ready[r]) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({tag, " ready"}, 64'(ok), 64'd1);
    if (ok) begin
      wr0 = wr_cnt;
      @(posedge clk);
      #1;
      bus.in_req_valid[r] = 1'b0;
      cyc = 1;
      ok  = 1'b0;
      for (int k = 0; k < 10; k++) begin
        if (bus.out_rsp_valid) begin
          ok = 1'b1;
          break;
        end
        @(posedge clk);
        #1;
        cyc++;
      end
      check({tag, " rsp_seen"}, 64'(ok), 64'd1);
      check({tag, " latency"}, 64'(cyc), 64'(exp_lat));
      check({tag, " rsp_id"}, 64'(bus.out_rsp_id), 64'(r));
      check({tag, " rsp_data"}, bus.out_rsp_data, exp_data);
`ifdef DMEM_ARB_MISALIGN_TRAP_EN
      last_err = bus.out_rsp_err;
`endif
      @(posedge clk);
      #1;
      check({tag, " rsp_pulse_end"}, 64'(bus.out_rsp_valid), 64'd0);
      check({tag, " idle_after"}, 64'(bus.out_busy), 64'd0);
      check({tag, " wr_pulses"}, 64'(wr_cnt - wr0), 64'(exp_wr));
    end else begin
      bus.in_req_valid[r] = 1'b0;
    end
  endtask

  initial begin
    bit   ok;
    int   acc_n;
    int   rsp_n;
    int   acc_id [4];
    int   acc_cyc [4];
    int   rid [4];
    logic [63:0] rdat [4];
    bit   both_hi;
    int   rsp0;

    total    = 0;
    bad      = 0;
    last_err = 1'b0;
    rst_n    = 1'b0;
    bus.in_req_valid    = 2'b00;
    bus.in_req_wr       = 2'b00;
    bus.in_req_size     = 4'd0;
    bus.in_req_unsigned = 2'b00;
    bus.in_req_addr     = 128'd0;
    bus.in_req_wdata    = 128'd0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst mem_wr_en", 64'(bus.out_mem_wr_en), 64'd0);
    check("rst mem_addr", bus.out_mem_addr, 64'd0);
    check("rst mem_wdata", bus.out_mem_wdata, 64'd0);
    check("rst rsp_valid", 64'(bus.out_rsp_valid), 64'd0);
    check("rst busy", 64'(bus.out_busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("idle ready no valid", 64'(bus.out_req_ready), 64'd0);

    // Doubleword store, then reload
    xact("st64 r0", 0, 1'b1, 2'd3, 1'b0, 64'h100, 64'h1122334455667788, 2, 64'd0, 1);
    xact("ld64 r0", 0, 1'b0, 2'd3, 1'b0, 64'h100, 64'd0, 2, 64'h1122334455667788, 0);
    // Byte store via read-modify-write, only the low byte of wdata lands
    xact("st8 r1", 1, 1'b1, 2'd0, 1'b0, 64'h100, 64'hDEADBEEFCAFE12AB, 3, 64'd0, 1);
    xact("ld64 r1", 1, 1'b0, 2'd3, 1'b0, 64'h100, 64'd0, 2, 64'h11223344556677AB, 0);
    xact("ld8 signed", 0, 1'b0, 2'd0, 1'b0, 64'h100, 64'd0, 2, 64'hFFFFFFFFFFFFFFAB, 0);
    xact("ld8 unsigned", 0, 1'b0, 2'd0, 1'b1, 64'h100, 64'd0, 2, 64'h00000000000000AB, 0);
    xact("ld16 0x106", 0, 1'b0, 2'd1, 1'b0, 64'h106, 64'd0, 2, 64'h0000000000001122, 0);
    // Half store: bytes 0x104/0x105 become 0x99/0x88
    xact("st16 0x104", 0, 1'b1, 2'd1, 1'b0, 64'h104, 64'hFFFFFFFFFFFF8899, 3, 64'd0, 1);
`ifdef DMEM_ARB_MISALIGN_TRAP_EN
    check("aligned rsp_err", 64'(last_err), 64'd0);
`endif
    xact("ld64 after st16", 1, 1'b0, 2'd3, 1'b0, 64'h100, 64'd0, 2, 64'h11228899556677AB, 0);
`ifdef DMEM_ARB_MISALIGN_TRAP_EN
    xact("ld32 0x102 trap", 0, 1'b0, 2'd2, 1'b0, 64'h102, 64'd0, 1, 64'd0, 0);
    check("misaligned rsp_err", 64'(last_err), 64'd1);
`else
    xact("ld32 0x102", 0, 1'b0, 2'd2, 1'b0, 64'h102, 64'd0, 2, 64'hFFFFFFFF88995566, 0);
`endif

    // Reset during the WR state of a half store
    @(negedge clk);
    drive(1, 1'b1, 2'd1, 1'b0, 64'h100, 64'h0000000000005A5A);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (bus.out_req_ready[1]) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("abort accept", 64'(ok), 64'd1);
    @(posedge clk);
    #1;
    bus.in_req_valid = 2'b00;
    @(posedge clk);
    #1;
    check("abort in WR", 64'(bus.out_mem_wr_en), 64'd1);
    rsp0  = rsp_cnt;
    rst_n = 1'b0;
    #1;
    check("abort wr_en drop", 64'(bus.out_mem_wr_en), 64'd0);
    check("abort busy", 64'(bus.out_busy), 64'd0);
    check("abort mem_addr", bus.out_mem_addr, 64'd0);
    check("abort mem_wdata", bus.out_mem_wdata, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("abort no response", 64'(rsp_cnt - rsp0), 64'd0);

    // Both requesters continuously valid: grants alternate starting with r0
    drive(0, 1'b0, 2'd3, 1'b0, 64'h100, 64'd0);
    drive(1, 1'b0, 2'd0, 1'b1, 64'h100, 64'd0);
    acc_n   = 0;
    rsp_n   = 0;
    both_hi = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (acc_n >= 4) bus.in_req_valid = 2'b00;
      #1;
      if (bus.out_req_ready == 2'b11) both_hi = 1'b1;
      if (((bus.in_req_valid & bus.out_req_ready) != 2'b00) && (acc_n < 4)) begin
        acc_id[acc_n]  = bus.out_req_ready[1] ? 1 : 0;
        acc_cyc[acc_n] = cyc_cnt;
        acc_n++;
      end
      if (bus.out_rsp_valid && (rsp_n < 4)) begin
        rid[rsp_n]  = 32'(bus.out_rsp_id);
        rdat[rsp_n] = bus.out_rsp_data;
        rsp_n++;
      end
      if (rsp_n >= 4) break;
      @(negedge clk);
    end
    bus.in_req_valid = 2'b00;
    check("rr accepts", 64'(acc_n), 64'd4);
    check("rr responses", 64'(rsp_n), 64'd4);
    check("rr ready both high", 64'(both_hi), 64'd0);
    if (acc_n == 4 && rsp_n == 4) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("rr grant %0d", i), 64'(acc_id[i]), 64'(i % 2));
        check($sformatf("rr rsp_id %0d", i), 64'(rid[i]), 64'(i % 2));
        check($sformatf("rr rsp_data %0d", i), rdat[i],
              (i % 2 == 0) ? 64'h11228899556677AB : 64'h00000000000000AB);
      end
      for (int i = 1; i < 4; i++) begin
        check($sformatf("rr accept spacing %0d", i), 64'(acc_cyc[i] - acc_cyc[i-1]), 64'd3);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
